// File: rtl/fifo_lane.sv
// fifo_lane: per-lane synchronous FIFO feeding one input of the L1 mux.
// Buffers DATA_WIDTH-bit words and returns them with a 1-cycle read latency.
// It provides full, empty, almost_full and almost_empty flags, plus an error
// output that reports overflow and underflow.
// Optional build macro FIFO_ERR_STICKY_EN: when defined, error is sticky and
// the err_code port is added (bit0 = overflow seen, bit1 = underflow seen).
module fifo_lane #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH      = 3,
  parameter int unsigned ALMOST_FULL_TH  = 6,
  parameter int unsigned ALMOST_EMPTY_TH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] dataIn,
  input  logic                  validIn,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
`ifdef FIFO_ERR_STICKY_EN
  , output logic [1:0]          err_code
`endif
);

  localparam int unsigned DEPTH_N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH  = (ADDR_WIDTH+1)'(DEPTH_N);
  localparam logic [ADDR_WIDTH:0] AF_TH  = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_TH  = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH_N-1];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;

  logic popAcc;
  logic pushAcc;
  logic overflow;
  logic underflow;

  // Flags decode only the registered count, so inputs cannot glitch them.
  always_comb begin
    full         = (count == DEPTH);
    empty        = (count == '0);
    almost_full  = (count >= AF_TH);
    almost_empty = (count <= AE_TH);
  end

  // Accept/reject decisions. A push while full is allowed only if a pop
  // frees a slot in the same cycle. A pop while empty never falls through.
  always_comb begin
    popAcc    = pop & ~empty;
    pushAcc   = validIn & (~full | popAcc);
    overflow  = validIn & full & ~popAcc;
    underflow = pop & empty;
  end

  // Storage write. Memory is not reset, so this block has no reset term.
  always_ff @(posedge clk) begin
    if (pushAcc) mem[wrPtr] <= dataIn;
  end

  // Pointers, occupancy and registered read port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
    end else begin
      if (pushAcc) wrPtr <= wrPtr + ADDR_WIDTH'(1);
      if (popAcc) begin
        rdPtr    <= rdPtr + ADDR_WIDTH'(1);
        dataOut  <= mem[rdPtr];
        validOut <= 1'b1;
      end else begin
        dataOut  <= '0;
        validOut <= 1'b0;
      end
      if (pushAcc && !popAcc)      count <= count + (ADDR_WIDTH+1)'(1);
      else if (popAcc && !pushAcc) count <= count - (ADDR_WIDTH+1)'(1);
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  // Sticky error and cause bits, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error    <= 1'b0;
      err_code <= '0;
    end else begin
      error    <= error | overflow | underflow;
      err_code <= err_code | {underflow, overflow};
    end
  end
`else
  // One-cycle error pulse following an overflow or underflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) error <= 1'b0;
    else        error <= overflow | underflow;
  end
`endif

endmodule

// File: tb/tb_fifo_lane.sv
// tb_fifo_lane: self-checking bench for fifo_lane with a queue-based reference.
module tb_fifo_lane;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] dataIn;
  logic       validIn;
  logic       pop;
  logic [7:0] dataOut;
  logic       validOut;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;
`ifdef FIFO_ERR_STICKY_EN
  logic [1:0] err_code;
`endif

  int unsigned checkCount = 0;
  int unsigned failCount  = 0;

  // Reference state: words held, plus the expected registered outputs.
  logic [7:0] refQ[$];
  logic [7:0] expData;
  logic       expValid;
  logic       expErr;
  logic [1:0] expCode;

  fifo_lane #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3),
    .ALMOST_FULL_TH(6),
    .ALMOST_EMPTY_TH(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .dataIn(dataIn),
    .validIn(validIn),
    .pop(pop),
    .dataOut(dataOut),
    .validOut(validOut),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .error(error)
`ifdef FIFO_ERR_STICKY_EN
    , .err_code(err_code)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    checkVal({tag, ".empty"},       32'(empty),        32'(refQ.size() == 0));
    checkVal({tag, ".full"},        32'(full),         32'(refQ.size() == 8));
    checkVal({tag, ".almostFull"},  32'(almost_full),  32'(refQ.size() >= 6));
    checkVal({tag, ".almostEmpty"}, 32'(almost_empty), 32'(refQ.size() <= 1));
    checkVal({tag, ".validOut"},    32'(validOut),     32'(expValid));
    checkVal({tag, ".dataOut"},     32'(dataOut),      32'(expData));
    checkVal({tag, ".error"},       32'(error),        32'(expErr));
`ifdef FIFO_ERR_STICKY_EN
    checkVal({tag, ".errCode"},     32'(err_code),     32'(expCode));
`endif
  endtask

  task automatic clearModel();
    refQ.delete();
    expData  = '0;
    expValid = 1'b0;
    expErr   = 1'b0;
    expCode  = '0;
  endtask

  // Apply one cycle of stimulus (called at a falling edge), advance the
  // model across the rising edge, then check at the next falling edge.
  task automatic cycle(input string tag, input logic v, input logic [7:0] d, input logic p);
    logic wasFull, wasEmpty, rd, ovf, unf;
    validIn = v;
    dataIn  = d;
    pop     = p;
    wasFull  = (refQ.size() == 8);
    wasEmpty = (refQ.size() == 0);
    rd  = p && !wasEmpty;
    ovf = v && wasFull && !rd;
    unf = p && wasEmpty;
    @(posedge clk);
    if (rd) begin
      expData  = refQ.pop_front();
      expValid = 1'b1;
    end else begin
      expData  = '0;
      expValid = 1'b0;
    end
    if (v && !ovf) refQ.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
    expErr  = expErr | ovf | unf;
    expCode = expCode | {unf, ovf};
`else
    expErr  = ovf | unf;
`endif
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    reset   = 1'b0;
    validIn = 1'b0;
    dataIn  = '0;
    pop     = 1'b0;
    clearModel();

    // Reset held for two cycles, released away from the rising edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkAll("reset");
    cycle("idle", 1'b0, 8'h00, 1'b0);

    // Fill with 0x11..0x88.
    for (int i = 1; i <= 8; i++) cycle("fill", 1'b1, 8'(i * 8'h11), 1'b0);
    checkVal("fullAfterFill", 32'(full), 32'd1);

    // Overflow: the word is dropped and error pulses.
    cycle("overflow", 1'b1, 8'hAA, 1'b0);
    checkVal("overflowErr", 32'(error), 32'd1);
    cycle("afterOvf", 1'b0, 8'h00, 1'b0);

    // Push and pop together while full.
    cycle("fullPushPop", 1'b1, 8'hBB, 1'b1);
    checkVal("fullPushPopData", 32'(dataOut), 32'h22 - 32'h11);

    // Drain everything (0x22..0x88, then 0xBB), then underflow once.
    for (int i = 0; i < 8; i++) cycle("drain", 1'b0, 8'h00, 1'b1);
    checkVal("drainLast", 32'(dataOut), 32'hBB);
    cycle("underflow", 1'b0, 8'h00, 1'b1);

    // Push and pop together while empty: no fall-through.
    cycle("emptyPushPop", 1'b1, 8'h5A, 1'b1);
    cycle("popFallthru", 1'b0, 8'h00, 1'b1);
    checkVal("fallthruData", 32'(dataOut), 32'h5A);

    // Asynchronous reset in the middle of a fill.
    for (int i = 0; i < 4; i++) cycle("preRst", 1'b1, 8'(8'hC0 + i), 1'b0);
    validIn = 1'b0;
    pop     = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    clearModel();
    checkAll("asyncRst");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    checkAll("rstRelease");
    cycle("popAfterRst", 1'b0, 8'h00, 1'b1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      logic v, p;
      v = ($urandom_range(0, 99) < 55);
      p = ($urandom_range(0, 99) < 45);
      cycle("rand", v, 8'($urandom), p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
